// File: rtl/cbp_train_ctrl_if.sv
// rtl/cbp_train_ctrl_if.sv - fetch/resolve/commit request and ED/MD training signal bundle
interface cbp_train_ctrl_if #(
  parameter int HIST_W = 7
);
  logic              F_valid_i;
  logic [HIST_W-1:0] F_PC_i;
  logic [HIST_W-1:0] F_train_global_history_i;
  logic              F_train_predict_i;
  logic              F_train_global_predict_i;
  logic              F_train_local_predict_i;
  logic              F_stall_o;
  logic              E_resolve_valid_i;
  logic              E_taken_i;
  logic              ED_train_valid_o;
  logic [HIST_W-1:0] ED_train_global_history_o;
  logic              ED_train_global_predict_o;
  logic              ED_train_global_taken_o;
  logic              ED_redirect_o;
  logic              M_commit_valid_i;
  logic              MD_train_valid_o;
  logic [HIST_W-1:0] MD_PC_o;
  logic [HIST_W-1:0] MD_train_global_history_o;
  logic              MD_train_predict_o;
  logic              MD_train_taken_o;
  logic              MD_train_global_predict_o;
  logic              MD_train_global_taken_o;
  logic              MD_train_local_predict_o;
  logic              MD_train_local_taken_o;
  logic              err_o;

  modport slave (
    input  F_valid_i, F_PC_i, F_train_global_history_i, F_train_predict_i,
           F_train_global_predict_i, F_train_local_predict_i,
           E_resolve_valid_i, E_taken_i, M_commit_valid_i,
    output F_stall_o,
           ED_train_valid_o, ED_train_global_history_o, ED_train_global_predict_o,
           ED_train_global_taken_o, ED_redirect_o,
           MD_train_valid_o, MD_PC_o, MD_train_global_history_o,
           MD_train_predict_o, MD_train_taken_o,
           MD_train_global_predict_o, MD_train_global_taken_o,
           MD_train_local_predict_o, MD_train_local_taken_o, err_o
  );

  modport master (
    output F_valid_i, F_PC_i, F_train_global_history_i, F_train_predict_i,
           F_train_global_predict_i, F_train_local_predict_i,
           E_resolve_valid_i, E_taken_i, M_commit_valid_i,
    input  F_stall_o,
           ED_train_valid_o, ED_train_global_history_o, ED_train_global_predict_o,
           ED_train_global_taken_o, ED_redirect_o,
           MD_train_valid_o, MD_PC_o, MD_train_global_history_o,
           MD_train_predict_o, MD_train_taken_o,
           MD_train_global_predict_o, MD_train_global_taken_o,
           MD_train_local_predict_o, MD_train_local_taken_o, err_o
  );
endinterface

// File: rtl/cbp_train_ctrl.sv
// rtl/cbp_train_ctrl.sv - in-order prediction queue producing ED repair and MD commit training
module cbp_train_ctrl #(
  parameter int HIST_W = 7,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input logic           clk_i,
  input logic           rst,
  cbp_train_ctrl_if.slave bus
);

  localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  // Entry storage; only the resolved bits need a reset value.
  logic [HIST_W-1:0] pc_mem   [DEPTH];
  logic [HIST_W-1:0] hist_mem [DEPTH];
  logic [DEPTH-1:0]  pred_mem, gpred_mem, lpred_mem, actual_mem;
  logic [DEPTH-1:0]  resolved_q;

  // head = oldest entry, res = oldest unresolved entry, tail = next free slot.
  // unres_q counts entries between res and tail so that a full queue with
  // nothing resolved is distinguishable from an empty one.
  logic [PTR_W-1:0] head_q, res_q, tail_q;
  logic [PTR_W:0]   count_q, unres_q;
  logic [PTR_W:0]   count_d, unres_d, squash_n;
  logic             stall, alloc, res_ok, cmt_ok, mispredict, proto_err;

  logic              ed_valid_q, ed_gpred_q, ed_gtaken_q, ed_redirect_q;
  logic [HIST_W-1:0] ed_hist_q;
  logic              md_valid_q, md_pred_q, md_taken_q, md_gpred_q, md_gtaken_q;
  logic              md_lpred_q, md_ltaken_q;
  logic [HIST_W-1:0] md_pc_q, md_hist_q;
  logic              err_q;

  // Qualify this cycle's alloc/resolve/commit requests against registered occupancy.
  always_comb begin
    stall      = (count_q == FULL);
    res_ok     = bus.E_resolve_valid_i && (unres_q != '0);
    cmt_ok     = bus.M_commit_valid_i && (count_q != unres_q) && resolved_q[head_q];
    mispredict = res_ok && (pred_mem[res_q] != bus.E_taken_i);
    // A fetch in the same cycle as a redirect is on the wrong path.
    alloc      = bus.F_valid_i && !stall && !mispredict;
    proto_err  = (bus.E_resolve_valid_i && !res_ok) ||
                 (bus.M_commit_valid_i && !cmt_ok) ||
                 (bus.F_valid_i && stall);
    // Everything younger than the mispredicted entry is dropped.
    squash_n   = mispredict ? (unres_q - CNT_ONE) : '0;
    count_d    = count_q + (PTR_W+1)'(alloc) - (PTR_W+1)'(cmt_ok) - squash_n;
    unres_d    = mispredict ? '0 : (unres_q + (PTR_W+1)'(alloc) - (PTR_W+1)'(res_ok));
  end

  // Pointer, occupancy, resolved-bit and sticky error state.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      head_q     <= '0;
      res_q      <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      unres_q    <= '0;
      resolved_q <= '0;
      err_q      <= 1'b0;
    end else begin
      count_q <= count_d;
      unres_q <= unres_d;
      if (proto_err) err_q <= 1'b1;
      if (cmt_ok) head_q <= head_q + PTR_ONE;
      if (res_ok) begin
        res_q             <= res_q + PTR_ONE;
        resolved_q[res_q] <= 1'b1;
      end
      if (mispredict) begin
        tail_q <= res_q + PTR_ONE;
      end else if (alloc) begin
        tail_q             <= tail_q + PTR_ONE;
        resolved_q[tail_q] <= 1'b0;
      end
    end
  end

  // Capture prediction payload at alloc and the actual direction at resolve.
  always_ff @(posedge clk_i) begin
    if (alloc) begin
      pc_mem[tail_q]    <= bus.F_PC_i;
      hist_mem[tail_q]  <= bus.F_train_global_history_i;
      pred_mem[tail_q]  <= bus.F_train_predict_i;
      gpred_mem[tail_q] <= bus.F_train_global_predict_i;
      lpred_mem[tail_q] <= bus.F_train_local_predict_i;
    end
    if (res_ok) actual_mem[res_q] <= bus.E_taken_i;
  end

  // ED repair pulse one cycle after a resolve; data holds between pulses.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      ed_valid_q    <= 1'b0;
      ed_hist_q     <= '0;
      ed_gpred_q    <= 1'b0;
      ed_gtaken_q   <= 1'b0;
      ed_redirect_q <= 1'b0;
    end else begin
      ed_valid_q    <= res_ok;
      ed_redirect_q <= mispredict;
      if (res_ok) begin
        ed_hist_q   <= hist_mem[res_q];
        ed_gpred_q  <= gpred_mem[res_q];
        ed_gtaken_q <= (gpred_mem[res_q] == bus.E_taken_i);
      end
    end
  end

  // MD training pulse one cycle after a commit; data holds between pulses.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      md_valid_q  <= 1'b0;
      md_pc_q     <= '0;
      md_hist_q   <= '0;
      md_pred_q   <= 1'b0;
      md_taken_q  <= 1'b0;
      md_gpred_q  <= 1'b0;
      md_gtaken_q <= 1'b0;
      md_lpred_q  <= 1'b0;
      md_ltaken_q <= 1'b0;
    end else begin
      md_valid_q <= cmt_ok;
      if (cmt_ok) begin
        md_pc_q     <= pc_mem[head_q];
        md_hist_q   <= hist_mem[head_q];
        md_pred_q   <= pred_mem[head_q];
        md_taken_q  <= (pred_mem[head_q] == actual_mem[head_q]);
        md_gpred_q  <= gpred_mem[head_q];
        md_gtaken_q <= (gpred_mem[head_q] == actual_mem[head_q]);
        md_lpred_q  <= lpred_mem[head_q];
        md_ltaken_q <= (lpred_mem[head_q] == actual_mem[head_q]);
      end
    end
  end

  assign bus.F_stall_o                 = stall;
  assign bus.ED_train_valid_o          = ed_valid_q;
  assign bus.ED_train_global_history_o = ed_hist_q;
  assign bus.ED_train_global_predict_o = ed_gpred_q;
  assign bus.ED_train_global_taken_o   = ed_gtaken_q;
  assign bus.ED_redirect_o             = ed_redirect_q;
  assign bus.MD_train_valid_o          = md_valid_q;
  assign bus.MD_PC_o                   = md_pc_q;
  assign bus.MD_train_global_history_o = md_hist_q;
  assign bus.MD_train_predict_o        = md_pred_q;
  assign bus.MD_train_taken_o          = md_taken_q;
  assign bus.MD_train_global_predict_o = md_gpred_q;
  assign bus.MD_train_global_taken_o   = md_gtaken_q;
  assign bus.MD_train_local_predict_o  = md_lpred_q;
  assign bus.MD_train_local_taken_o    = md_ltaken_q;
  assign bus.err_o                     = err_q;

endmodule

// File: tb/tb_cbp_train_ctrl.sv
// tb/tb_cbp_train_ctrl.sv - queue-model scoreboard plus directed scenarios for cbp_train_ctrl
module tb_cbp_train_ctrl;
  localparam int HIST_W = 7;
  localparam int DEPTH  = 8;

  logic clk_i = 1'b0;
  logic rst   = 1'b1;
  always #5 clk_i = ~clk_i;

  cbp_train_ctrl_if #(.HIST_W(HIST_W)) bus();

  cbp_train_ctrl #(.HIST_W(HIST_W), .DEPTH(DEPTH), .PTR_W(3)) dut (
    .clk_i (clk_i),
    .rst   (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk7(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: an ordered list of in-flight branches; the first nres are resolved.
  typedef struct {
    logic [6:0] pc;
    logic [6:0] hist;
    logic       p, g, l, act;
  } ent_t;

  ent_t q[$];
  int   nres = 0;
  bit   model_live = 0;
  logic e_ed_v, e_ed_g, e_ed_gt, e_redir, e_err;
  logic [6:0] e_ed_hist, e_md_pc, e_md_hist;
  logic e_md_v, e_md_p, e_md_t, e_md_g, e_md_gt, e_md_l, e_md_lt;

  always @(posedge clk_i) begin : model
    int   unres;
    bit   do_c, do_r, mis, full_pre;
    ent_t c, n;
    if (rst) begin
      q.delete();
      nres = 0;
      model_live = 1;
      {e_ed_v, e_ed_g, e_ed_gt, e_redir, e_err} = '0;
      e_ed_hist = '0; e_md_pc = '0; e_md_hist = '0;
      {e_md_v, e_md_p, e_md_t, e_md_g, e_md_gt, e_md_l, e_md_lt} = '0;
    end else if (model_live) begin
      unres    = q.size() - nres;
      full_pre = (q.size() == DEPTH);
      do_c     = bus.M_commit_valid_i && (nres > 0);
      do_r     = bus.E_resolve_valid_i && (unres > 0);
      if (bus.M_commit_valid_i && !do_c) e_err = 1;
      if (bus.E_resolve_valid_i && !do_r) e_err = 1;
      if (bus.F_valid_i && full_pre) e_err = 1;
      e_ed_v = 0; e_redir = 0; e_md_v = 0; mis = 0;
      if (do_c) begin
        c = q[0];
        e_md_v = 1; e_md_pc = c.pc; e_md_hist = c.hist;
        e_md_p = c.p; e_md_t = (c.p == c.act);
        e_md_g = c.g; e_md_gt = (c.g == c.act);
        e_md_l = c.l; e_md_lt = (c.l == c.act);
      end
      if (do_r) begin
        q[nres].act = bus.E_taken_i;
        mis = (q[nres].p != bus.E_taken_i);
        e_ed_v = 1; e_ed_hist = q[nres].hist; e_ed_g = q[nres].g;
        e_ed_gt = (q[nres].g == bus.E_taken_i);
        e_redir = mis;
        if (mis) while (q.size() > nres + 1) void'(q.pop_back());
      end
      if (bus.F_valid_i && !full_pre && !mis) begin
        n.pc = bus.F_PC_i; n.hist = bus.F_train_global_history_i;
        n.p = bus.F_train_predict_i; n.g = bus.F_train_global_predict_i;
        n.l = bus.F_train_local_predict_i; n.act = 1'b0;
        q.push_back(n);
      end
      if (do_c) void'(q.pop_front());
      nres = nres + int'(do_r) - int'(do_c);
    end
  end

  // Compare every observable output against the reference away from the clock edge.
  always @(negedge clk_i) begin
    if (model_live) begin
      chk1("F_stall_o", bus.F_stall_o, (q.size() == DEPTH));
      chk1("err_o", bus.err_o, e_err);
      chk1("ED_valid", bus.ED_train_valid_o, e_ed_v);
      chk1("ED_redirect", bus.ED_redirect_o, e_redir);
      chk7("ED_hist", bus.ED_train_global_history_o, e_ed_hist);
      chk1("ED_gpred", bus.ED_train_global_predict_o, e_ed_g);
      chk1("ED_gtaken", bus.ED_train_global_taken_o, e_ed_gt);
      chk1("MD_valid", bus.MD_train_valid_o, e_md_v);
      chk7("MD_PC", bus.MD_PC_o, e_md_pc);
      chk7("MD_hist", bus.MD_train_global_history_o, e_md_hist);
      chk1("MD_pred", bus.MD_train_predict_o, e_md_p);
      chk1("MD_taken", bus.MD_train_taken_o, e_md_t);
      chk1("MD_gpred", bus.MD_train_global_predict_o, e_md_g);
      chk1("MD_gtaken", bus.MD_train_global_taken_o, e_md_gt);
      chk1("MD_lpred", bus.MD_train_local_predict_o, e_md_l);
      chk1("MD_ltaken", bus.MD_train_local_taken_o, e_md_lt);
    end
  end

  // One cycle of stimulus; history = pc ^ 0x17, global = final, local = ~final.
  task automatic drive(input logic fv, input logic [6:0] pc, input logic p,
                       input logic ev, input logic et, input logic mv);
    bus.F_valid_i = fv;
    bus.F_PC_i = pc;
    bus.F_train_global_history_i = pc ^ 7'h17;
    bus.F_train_predict_i = p;
    bus.F_train_global_predict_i = p;
    bus.F_train_local_predict_i = ~p;
    bus.E_resolve_valid_i = ev;
    bus.E_taken_i = et;
    bus.M_commit_valid_i = mv;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    do_reset();
    chk1("reset ED_valid", bus.ED_train_valid_o, 1'b0);
    chk1("reset MD_valid", bus.MD_train_valid_o, 1'b0);
    chk1("reset err", bus.err_o, 1'b0);
    chk1("reset stall", bus.F_stall_o, 1'b0);
    chk7("reset MD_PC", bus.MD_PC_o, 7'd0);

    // Basic alloc / resolve / commit
    drive(1, 7'd5, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0);
    chk1("t1 ED_valid", bus.ED_train_valid_o, 1'b1);
    chk1("t1 ED_gtaken", bus.ED_train_global_taken_o, 1'b1);
    chk1("t1 ED_redirect", bus.ED_redirect_o, 1'b0);
    chk7("t1 ED_hist", bus.ED_train_global_history_o, 7'h12);
    drive(0, 0, 0, 0, 0, 1);
    chk1("t1 MD_valid", bus.MD_train_valid_o, 1'b1);
    chk7("t1 MD_PC", bus.MD_PC_o, 7'd5);
    chk1("t1 MD_taken", bus.MD_train_taken_o, 1'b1);
    chk1("t1 MD_gtaken", bus.MD_train_global_taken_o, 1'b1);
    chk1("t1 MD_ltaken", bus.MD_train_local_taken_o, 1'b0);
    drive(0, 0, 0, 0, 0, 0);
    chk1("t1 MD_pulse_end", bus.MD_train_valid_o, 1'b0);

    // Fill to full, overflow, then release
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive(1, 7'(i + 32), 1, 0, 0, 0);
    chk1("t2 stall_full", bus.F_stall_o, 1'b1);
    chk1("t2 err_before", bus.err_o, 1'b0);
    drive(1, 7'd99, 1, 0, 0, 0);
    chk1("t2 err_overflow", bus.err_o, 1'b1);
    drive(0, 0, 0, 1, 1, 0);
    chk1("t2 stall_after_resolve", bus.F_stall_o, 1'b1);
    drive(0, 0, 0, 0, 0, 1);
    chk1("t2 stall_released", bus.F_stall_o, 1'b0);
    chk7("t2 MD_PC", bus.MD_PC_o, 7'd32);

    // Mispredict squashes younger entries
    do_reset();
    drive(1, 7'd10, 1, 0, 0, 0);
    drive(1, 7'd11, 1, 0, 0, 0);
    drive(1, 7'd12, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk1("t3 redirect", bus.ED_redirect_o, 1'b1);
    chk1("t3 ED_gtaken", bus.ED_train_global_taken_o, 1'b0);
    drive(0, 0, 0, 0, 0, 1);
    chk7("t3 MD_PC", bus.MD_PC_o, 7'd10);
    chk1("t3 MD_taken", bus.MD_train_taken_o, 1'b0);
    chk1("t3 err_before", bus.err_o, 1'b0);
    drive(0, 0, 0, 0, 0, 1);
    chk1("t3 err_extra_commit", bus.err_o, 1'b1);
    chk1("t3 no_MD_pulse", bus.MD_train_valid_o, 1'b0);

    // Steady alloc+resolve+commit, pointers wrap
    do_reset();
    drive(1, 7'd0, 1, 0, 0, 0);
    drive(1, 7'd1, 1, 1, 1, 0);
    for (int k = 0; k < 20; k++) begin
      drive(1, 7'(k + 2), 1, 1, 1, 1);
      chk7("t4 MD_order", bus.MD_PC_o, 7'(k));
      chk1("t4 stall", bus.F_stall_o, 1'b0);
    end
    chk1("t4 err", bus.err_o, 1'b0);

    // Mispredict same cycle as fetch drops the fetch
    do_reset();
    drive(1, 7'd20, 1, 0, 0, 0);
    drive(1, 7'd21, 1, 1, 0, 0);
    chk1("t5 redirect", bus.ED_redirect_o, 1'b1);
    drive(0, 0, 0, 0, 0, 1);
    chk7("t5 MD_PC", bus.MD_PC_o, 7'd20);
    chk1("t5 err_before", bus.err_o, 1'b0);
    drive(0, 0, 0, 1, 1, 0);
    chk1("t5 err_dropped", bus.err_o, 1'b1);

    // Reset with entries queued
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, 7'(i + 40), 1, (i > 0), 1, 0);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    chk1("t6 MD_valid", bus.MD_train_valid_o, 1'b0);
    chk1("t6 ED_valid", bus.ED_train_valid_o, 1'b0);
    chk7("t6 ED_hist", bus.ED_train_global_history_o, 7'd0);
    chk1("t6 stall", bus.F_stall_o, 1'b0);
    drive(0, 0, 0, 0, 0, 1);
    chk1("t6 no_MD", bus.MD_train_valid_o, 1'b0);
    chk1("t6 err_empty", bus.err_o, 1'b1);

    // Randomized traffic against the reference
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.F_valid_i = ($urandom_range(0, 99) < 60);
      bus.F_PC_i = 7'($urandom);
      bus.F_train_global_history_i = 7'($urandom);
      bus.F_train_predict_i = 1'($urandom);
      bus.F_train_global_predict_i = 1'($urandom);
      bus.F_train_local_predict_i = 1'($urandom);
      bus.E_resolve_valid_i = ($urandom_range(0, 99) < 50);
      bus.E_taken_i = 1'($urandom);
      bus.M_commit_valid_i = ($urandom_range(0, 99) < 45);
      @(posedge clk_i);
      #1;
    end
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
